// File: rtl/arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, grant selects,
// and the counter width used for latency and starvation tracking.
package arb_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] BUSY_IF = 2'b01;
    localparam logic [1:0] BUSY_DM = 2'b10;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;

endpackage

// File: rtl/arb_grant_pick.sv
// Priority decision between fetch and data ports: data wins unless fetch has
// been passed over STARVE_MAX times in a row.
module arb_grant_pick
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             if_req,
    input  logic             dm_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_if,
    output logic             grant_dm
);

    logic if_forced;

    assign if_forced = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
    assign grant_dm  = dm_req && !if_forced;
    assign grant_if  = if_req && !grant_dm;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data port,
// sequencing each access over a fixed latency and pulsing a per-port ready.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] lat_cnt_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             grant_if;
    logic             grant_dm;
    logic [1:0]       gnt_sel;
    logic             data_phase;

    arb_grant_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_grant_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .starve_cnt(starve_cnt_q),
        .grant_if  (grant_if),
        .grant_dm  (grant_dm)
    );

    assign gnt_sel = (state_q == IDLE) ? {grant_dm, grant_if} : GNT_NONE;

    // lat_cnt holds during the strobe cycle so ready lands MEM_LAT cycles after mem_en.
    assign data_phase = (state_q != IDLE) && !mem_en && (lat_cnt_q == CNT_W'(1));

    assign if_ready  = data_phase && (state_q == BUSY_IF);
    assign dm_ready  = data_phase && (state_q == BUSY_DM);
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
        end else begin
            mem_en <= 1'b0;

            if (!if_req || (gnt_sel == GNT_IF)) begin
                starve_cnt_q <= '0;
            end else if ((gnt_sel == GNT_DM) && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    case (gnt_sel)
                        GNT_DM: begin
                            state_q   <= BUSY_DM;
                            mem_en    <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            lat_cnt_q <= CNT_W'(MEM_LAT);
                        end
                        GNT_IF: begin
                            state_q   <= BUSY_IF;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            lat_cnt_q <= CNT_W'(MEM_LAT);
                        end
                        default: ;
                    endcase
                end
                BUSY_IF, BUSY_DM: begin
                    if (data_phase) begin
                        state_q   <= IDLE;
                        lat_cnt_q <= '0;
                        if (state_q == BUSY_IF) begin
                            if_rdata <= mem_rdata;
                        end else if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end else if (!mem_en) begin
                        lat_cnt_q <= lat_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: stimulus tasks push expected ready cycles, data and memory
// strobes; negedge monitors pop and compare whenever the DUT presents them.
module tb_unified_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (MEM_LAT = 2, STARVE_MAX = 4)
    logic        if_req, if_ready, dm_req, dm_we, dm_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, stall_if, stall_mem, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    // Latency-sweep DUTs (MEM_LAT = 1 and 5), fetch port only
    logic        l1_req, l1_ready, l1_dmr, l1_en, l1_we, l1_sif, l1_smem, l1_busy;
    logic [31:0] l1_rdata, l1_dmrd, l1_maddr, l1_mwdata, l1_mrdata;
    logic        l5_req, l5_ready, l5_dmr, l5_en, l5_we, l5_sif, l5_smem, l5_busy;
    logic [31:0] l5_rdata, l5_dmrd, l5_maddr, l5_mwdata, l5_mrdata;
    logic [31:0] lx_addr;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
    ) dut_l1 (
        .clk(clk), .reset(rst_n),
        .if_req(l1_req), .if_addr(lx_addr), .if_ready(l1_ready), .if_rdata(l1_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ready(l1_dmr), .dm_rdata(l1_dmrd),
        .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_maddr), .mem_wdata(l1_mwdata),
        .mem_rdata(l1_mrdata), .stall_if(l1_sif), .stall_mem(l1_smem), .busy(l1_busy)
    );

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(5), .STARVE_MAX(4)
    ) dut_l5 (
        .clk(clk), .reset(rst_n),
        .if_req(l5_req), .if_addr(lx_addr), .if_ready(l5_ready), .if_rdata(l5_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ready(l5_dmr), .dm_rdata(l5_dmrd),
        .mem_en(l5_en), .mem_we(l5_we), .mem_addr(l5_maddr), .mem_wdata(l5_mwdata),
        .mem_rdata(l5_mrdata), .stall_if(l5_sif), .stall_mem(l5_smem), .busy(l5_busy)
    );

    // Memory models: unwritten word at address a is {16'hC0DE, a[15:0]};
    // read data is driven only in the cycle MEM_LAT after the strobe.
    logic [31:0] wdat [256];
    logic        wval [256];
    int          cd, cd1, cd5;

    initial foreach (wval[i]) wval[i] = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd <= 0; cd1 <= 0; cd5 <= 0;
        end else begin
            if (mem_en) begin
                cd <= 2;
                if (mem_we) begin
                    wdat[mem_addr[9:2]] <= mem_wdata;
                    wval[mem_addr[9:2]] <= 1'b1;
                end
            end else if (cd > 0) cd <= cd - 1;
            if (l1_en) cd1 <= 1; else if (cd1 > 0) cd1 <= cd1 - 1;
            if (l5_en) cd5 <= 5; else if (cd5 > 0) cd5 <= cd5 - 1;
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0_BAD0;
        if (cd == 1) begin
            mem_rdata = wval[mem_addr[9:2]] ? wdat[mem_addr[9:2]] : {16'hC0DE, mem_addr[15:0]};
        end
    end
    assign l1_mrdata = (cd1 == 1) ? {16'hC0DE, l1_maddr[15:0]} : 32'hBAD0_BAD0;
    assign l5_mrdata = (cd5 == 1) ? {16'hC0DE, l5_maddr[15:0]} : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards
    exp_t    if_q[$], dm_q[$];
    strobe_t st_q[$];
    logic [31:0] l1_q[$], l5_q[$];
    exp_t    e_mon;
    int      idx, l1_en_cyc, l5_en_cyc;
    logic [31:0] if_pend, dm_pend, l1_pend, l5_pend;
    bit      if_chk = 0, dm_chk = 0, l1_chk = 0, l5_chk = 0;

    always @(negedge clk) begin
        if (if_chk) begin check("if_rdata", if_rdata, if_pend); if_chk = 0; end
        if (dm_chk) begin check("dm_rdata", dm_rdata, dm_pend); dm_chk = 0; end
        if (l1_chk) begin check("lat1_if_rdata", l1_rdata, l1_pend); l1_chk = 0; end
        if (l5_chk) begin check("lat5_if_rdata", l5_rdata, l5_pend); l5_chk = 0; end
        if (rst_n) begin
            if (if_ready) begin
                check("if_ready_expected", 32'(if_q.size() != 0), 32'd1);
                if (if_q.size() != 0) begin
                    e_mon = if_q.pop_front();
                    check("if_ready_cycle", cyc, e_mon.cyc);
                    if_pend = e_mon.data; if_chk = 1;
                end
            end
            if (dm_ready) begin
                check("dm_ready_expected", 32'(dm_q.size() != 0), 32'd1);
                if (dm_q.size() != 0) begin
                    e_mon = dm_q.pop_front();
                    check("dm_ready_cycle", cyc, e_mon.cyc);
                    dm_pend = e_mon.data; dm_chk = 1;
                end
            end
            if (mem_en) begin
                idx = -1;
                foreach (st_q[i]) if (st_q[i].cyc == cyc) idx = i;
                check("mem_en_expected", 32'(idx >= 0), 32'd1);
                if (idx >= 0) begin
                    check("mem_we", 32'(mem_we), 32'(st_q[idx].we));
                    check("mem_addr", mem_addr, st_q[idx].addr);
                    if (st_q[idx].we) check("mem_wdata", mem_wdata, st_q[idx].wdata);
                    st_q.delete(idx);
                end
            end
            if (l1_en) l1_en_cyc = cyc;
            if (l5_en) l5_en_cyc = cyc;
            if (l1_ready) begin
                check("lat1_ready_delay", cyc - l1_en_cyc, 1);
                check("lat1_ready_expected", 32'(l1_q.size() != 0), 32'd1);
                if (l1_q.size() != 0) begin l1_pend = l1_q.pop_front(); l1_chk = 1; end
            end
            if (l5_ready) begin
                check("lat5_ready_delay", cyc - l5_en_cyc, 5);
                check("lat5_ready_expected", 32'(l5_q.size() != 0), 32'd1);
                if (l5_q.size() != 0) begin l5_pend = l5_q.pop_front(); l5_chk = 1; end
            end
        end
    end

    // lat = cycles from the request cycle to the expected ready pulse
    task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_rd, input int lat);
        int n;
        exp_t e;
        strobe_t s;
        if_req = 1'b1; if_addr = addr;
        e.cyc = cyc + lat; e.data = exp_rd; if_q.push_back(e);
        s.cyc = cyc + lat - 2; s.we = 1'b0; s.addr = addr; s.wdata = '0; st_q.push_back(s);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (if_ready) begin check("stall_if_in_ready", 32'(stall_if), 32'd0); break; end
            check("stall_if_waiting", 32'(stall_if), 32'd1);
            n++;
        end
        check("if_ready_seen", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic dm_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input int lat, input bit keep);
        int n;
        exp_t e;
        strobe_t s;
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        e.cyc = cyc + lat; e.data = exp_rd; dm_q.push_back(e);
        s.cyc = cyc + lat - 2; s.we = we; s.addr = addr; s.wdata = wdata; st_q.push_back(s);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (dm_ready) begin check("stall_mem_in_ready", 32'(stall_mem), 32'd0); break; end
            check("stall_mem_waiting", 32'(stall_mem), 32'd1);
            n++;
        end
        check("dm_ready_seen", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        if (!keep) begin dm_req = 1'b0; dm_we = 1'b0; end
    endtask

    task automatic lat_fetch(input logic [31:0] addr, input logic [31:0] exp_rd);
        lx_addr = addr; l1_req = 1'b1; l5_req = 1'b1;
        l1_q.push_back(exp_rd); l5_q.push_back(exp_rd);
        fork
            begin
                int n = 0;
                while (n < 50) begin @(negedge clk); if (l1_ready) break; n++; end
                check("lat1_ready_seen", 32'(n < 50), 32'd1);
                @(posedge clk); #1; l1_req = 1'b0;
            end
            begin
                int n = 0;
                while (n < 50) begin @(negedge clk); if (l5_ready) break; n++; end
                check("lat5_ready_seen", 32'(n < 50), 32'd1);
                @(posedge clk); #1; l5_req = 1'b0;
            end
        join
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        l1_req = 0; l5_req = 0; lx_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain fetch
        if_access(32'h0000_0004, 32'hC0DE_0004, 3);

        // Simultaneous: DM first, IF in the next IDLE
        fork
            dm_access(32'h0000_0100, 1'b0, 32'h0, 32'hC0DE_0100, 3, 1'b0);
            if_access(32'h0000_0008, 32'hC0DE_0008, 7);
        join

        // Starvation: four DM grants, fifth goes to IF, then the held DM
        fork
            begin
                dm_access(32'h0000_0300, 1'b0, 32'h0, 32'hC0DE_0300, 3, 1'b1);
                dm_access(32'h0000_0304, 1'b0, 32'h0, 32'hC0DE_0304, 3, 1'b1);
                dm_access(32'h0000_0308, 1'b0, 32'h0, 32'hC0DE_0308, 3, 1'b1);
                dm_access(32'h0000_030C, 1'b0, 32'h0, 32'hC0DE_030C, 3, 1'b1);
                dm_access(32'h0000_0310, 1'b0, 32'h0, 32'hC0DE_0310, 7, 1'b0);
            end
            if_access(32'h0000_000C, 32'hC0DE_000C, 19);
            begin
                repeat (16) @(posedge clk);
                #1 check("starve_cnt_at_limit", 32'(dut.starve_cnt_q), 32'd4);
                @(posedge clk);
                #1 check("starve_cnt_after_if", 32'(dut.starve_cnt_q), 32'd0);
            end
        join

        // Store leaves dm_rdata alone, load returns stored word
        dm_access(32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 32'hC0DE_0310, 3, 1'b0);
        dm_access(32'h0000_0200, 1'b0, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);

        // Reset in the middle of a DM read: access dropped, no ready
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0040;
        begin
            strobe_t s;
            s.cyc = cyc + 1; s.we = 1'b0; s.addr = 32'h0000_0040; s.wdata = '0;
            st_q.push_back(s);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0; dm_req = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dm_ready", 32'(dm_ready), 32'd0);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        check("midrst_dm_rdata", dm_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        if_access(32'h0000_0004, 32'hC0DE_0004, 3);

        // Latency sweep on the MEM_LAT = 1 and 5 instances
        lat_fetch(32'h0000_0010, 32'hC0DE_0010);
        lat_fetch(32'h0000_0014, 32'hC0DE_0014);
        lat_fetch(32'h0000_0018, 32'hC0DE_0018);

        repeat (4) @(posedge clk);
        #1;
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("dm_q_drained", 32'(dm_q.size()), 32'd0);
        check("strobe_q_drained", 32'(st_q.size()), 32'd0);
        check("lat_q_drained", 32'(l1_q.size() + l5_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (MEM stage).
- Sequences each access over a fixed memory latency and returns read data plus a one-cycle ready pulse to the requester.
- Exports stall_if and stall_mem, which the pipeline ORs into its existing PC/IFID/IDEX/EXMEM stall controls.
- Sits between the pipeline and the memory model, replacing the separate instMemory and dataMemory instances.

Parameters:
- ADDR_W, 32, address width (byte address, passed through unmodified)
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from mem_en assertion to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before IF is forced; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_ready  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched instruction; registered, held until the next IF completion
- dm_req  in  1  data request; held high until dm_ready
- dm_we  in  1  1 = write, 0 = read; stable with dm_req
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ready  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_W  load data; registered, held until the next DM read completion
- mem_en  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- stall_if  out  1  combinational: if_req & ~if_ready
- stall_mem  out  1  combinational: dm_req & ~dm_ready
- busy  out  1  state != IDLE

Behaviour:
- **Reset** (reset low, asynchronous): state = IDLE, lat_cnt = 0, starve_cnt = 0. All registered outputs are 0, including if_rdata and dm_rdata.
- **Reset mid-access:** the access is dropped and no ready pulse is issued. Requesters re-present after reset.
- **IDLE:** samples requests.
  - Grant rule: if dm_req and not (if_req and starve_cnt == STARVE_MAX) → grant DM; else if if_req → grant IF; else stay in IDLE.
  - On a grant: register mem_addr/mem_we/mem_wdata from the granted port (mem_we = 0 for IF). Assert mem_en for exactly the next cycle. Load lat_cnt = MEM_LAT. Go to BUSY_IF or BUSY_DM.
- **starve_cnt:**
  - Increments (saturating at STARVE_MAX) on each DM grant made while if_req is high.
  - Clears on an IF grant, and in any cycle where if_req is low.
- **BUSY_x:**
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 1, mem_rdata is valid. Capture it into if_rdata (BUSY_IF) or dm_rdata (BUSY_DM read only); writes leave dm_rdata unchanged.
  - Pulse the matching ready for that same cycle, with data visible on the following edge. Then return to IDLE.
- **Latency and throughput:**
  - Request sampled in IDLE at cycle t → mem_en at t+1 → ready at t+MEM_LAT+1 → IDLE again at t+MEM_LAT+2.
  - Peak throughput is one access per MEM_LAT+2 cycles.
- **Double-serve protection:** the ready cycle is never an IDLE cycle. The requester deasserts or advances req in the cycle after ready, before the next sample, so no access is served twice.
- **Simultaneous requests:** DM wins unless the starvation limit is reached.
- **Request withdrawn mid-access:** the access completes anyway and ready still pulses.
- **Addresses:** passed through unmodified; no alignment checking. lat_cnt and starve_cnt are 4 bits wide.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding: IDLE = 2'b00, BUSY_IF = 2'b01, BUSY_DM = 2'b10
  - grant-select constants
  - the 4-bit counter width
- One sub-module, arb_grant_pick: combinational priority/anti-starvation decision from (if_req, dm_req, starve_cnt) → (grant_if, grant_dm).

Test Plan (all cases use MEM_LAT = 2, STARVE_MAX = 4 unless stated):
- **Reset:** assert reset low mid-BUSY_DM → all outputs 0 immediately, no dm_ready. Release reset, then if_req with if_addr = 0x0000_0004 → mem_en at cycle 1, if_ready at cycle 3, if_rdata = memory word at 0x4.
- **Simultaneous requests:** if_req and dm_req (read, addr 0x100) both high → DM served first (dm_ready at cycle 3). IF granted in the next IDLE, if_ready at cycle 7.
- **Starvation:** dm_req held high continuously with new addresses each access, if_req high → exactly 4 DM grants, then IF forced on the 5th grant, then starve_cnt = 0.
- **Store then load:** dm_we = 1, addr 0x200, wdata 0xDEAD_BEEF → mem_we = 1 with mem_en, dm_rdata unchanged. Then a read of 0x200 → dm_rdata = 0xDEAD_BEEF.
- **Stall outputs:** stall_mem is high from dm_req rise until the dm_ready cycle, and low in the ready cycle. stall_if tracks if_req the same way.
- **Latency sweep:** MEM_LAT = 1 and MEM_LAT = 5 → ready is exactly MEM_LAT cycles after mem_en, and if_rdata matches memory each time.
